// File: rtl/conway_board_scanner.sv
// conway_board_scanner
//   Reader side of the Conway cell array. Every STEP_CYCLES clocks it snapshots
//   the whole board, streams the snapshot out one row word at a time over a
//   valid/ready interface, and only after the last row is accepted issues the
//   one-cycle step_ena strobe that advances every cell one generation. Readout
//   and generation updates never overlap, so each frame is one consistent
//   generation.
//
//   Optional feature: define CONWAY_SCAN_POPCOUNT_EN to add out_alive, the
//   number of live cells in the current snapshot.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   cells_q    live board, cell (r,c) = bit r*COLS+c
//   step_ena   one-cycle generation-advance pulse to every cell
//   out_data   row word, out_data[c] = snapshot cell (out_row,c)
//   out_row    index of the row on out_data
//   out_last   high with out_valid on the final row
//   out_valid  row word valid
//   out_ready  sink accepts the word on a posedge with out_valid high
//   busy       high while streaming or stepping
//   out_alive  (CONWAY_SCAN_POPCOUNT_EN only) live-cell count of the snapshot
module conway_board_scanner #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int STEP_CYCLES = 1_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ROWS*COLS-1:0]          cells_q,
  output logic                          step_ena,
  output logic [COLS-1:0]               out_data,
  output logic [$clog2(ROWS)-1:0]       out_row,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy
`ifdef CONWAY_SCAN_POPCOUNT_EN
  ,
  output logic [$clog2(ROWS*COLS+1)-1:0] out_alive
`endif
);

  localparam int RW = $clog2(ROWS);
  localparam int WW = $clog2(STEP_CYCLES + 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {S_WAIT, S_SEND, S_STEP} state_t;

  state_t                      state, state_d;
  logic [WW-1:0]               wait_cnt, wait_d;
  // Packed so that snap[r] is exactly row r of the flat cells_q vector.
  logic [ROWS-1:0][COLS-1:0]   snap, snap_d;
  logic [COLS-1:0]             data_d;
  logic [RW-1:0]               row_d, row_nxt;
  logic                        valid_d, last_d, step_d, busy_d;

`ifdef CONWAY_SCAN_POPCOUNT_EN
  localparam int AW = $clog2(ROWS*COLS + 1);
  logic [AW-1:0] alive_d;
`endif

  // out_row doubles as the row counter: it is registered and only ever
  // advances on an accepted word, which is exactly the row pointer's rule.
  assign row_nxt = out_row + 1'b1;

  always_comb begin
    state_d  = state;
    wait_d   = wait_cnt;
    snap_d   = snap;
    data_d   = out_data;
    row_d    = out_row;
    valid_d  = out_valid;
    last_d   = out_last;
    step_d   = 1'b0;
    busy_d   = busy;
`ifdef CONWAY_SCAN_POPCOUNT_EN
    alive_d  = out_alive;
`endif
    case (state)
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          snap_d  = cells_q;
          data_d  = cells_q[COLS-1:0];
          row_d   = '0;
          valid_d = 1'b1;
          last_d  = 1'b0;
          busy_d  = 1'b1;
          wait_d  = '0;
          state_d = S_SEND;
`ifdef CONWAY_SCAN_POPCOUNT_EN
          alive_d = '0;
          for (int unsigned i = 0; i < ROWS*COLS; i++)
            alive_d = alive_d + AW'(cells_q[i]);
`endif
        end else begin
          wait_d = wait_cnt + 1'b1;
        end
      end
      S_SEND: begin
        // out_valid is always high here; payload holds until accepted.
        if (out_ready) begin
          if (out_row == LAST_ROW) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            step_d  = 1'b1;
            state_d = S_STEP;
          end else begin
            row_d  = row_nxt;
            data_d = snap[row_nxt];
            last_d = (row_nxt == LAST_ROW);
          end
        end
      end
      S_STEP: begin
        busy_d  = 1'b0;
        wait_d  = '0;
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_WAIT;
      wait_cnt  <= '0;
      snap      <= '0;
      out_data  <= '0;
      out_row   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      step_ena  <= 1'b0;
      busy      <= 1'b0;
`ifdef CONWAY_SCAN_POPCOUNT_EN
      out_alive <= '0;
`endif
    end else begin
      state     <= state_d;
      wait_cnt  <= wait_d;
      snap      <= snap_d;
      out_data  <= data_d;
      out_row   <= row_d;
      out_valid <= valid_d;
      out_last  <= last_d;
      step_ena  <= step_d;
      busy      <= busy_d;
`ifdef CONWAY_SCAN_POPCOUNT_EN
      out_alive <= alive_d;
`endif
    end
  end

endmodule

// File: tb/tb_conway_board_scanner.sv
// tb_conway_board_scanner
//   Directed bench for conway_board_scanner (ROWS=4, COLS=4, STEP_CYCLES=3).
//   A frame-level model (a queue of pending row words plus a wait counter)
//   predicts the outputs every cycle; literal expectations pin latencies,
//   frame contents and the blinker sequence. Build with
//   CONWAY_SCAN_POPCOUNT_EN defined to also check out_alive.
module tb_conway_board_scanner;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int STEP_CYCLES = 3;
  localparam int AW = $clog2(ROWS*COLS+1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [ROWS*COLS-1:0] cells_q = '0;
  logic                 out_ready = 1'b1;
  logic                 step_ena, out_last, out_valid, busy;
  logic [COLS-1:0]      out_data;
  logic [1:0]           out_row;
`ifdef CONWAY_SCAN_POPCOUNT_EN
  logic [AW-1:0]        out_alive;
`endif

  always #5 clk = ~clk;

  conway_board_scanner #(.ROWS(ROWS), .COLS(COLS), .STEP_CYCLES(STEP_CYCLES)) dut (
    .clk(clk), .rst(rst), .cells_q(cells_q), .step_ena(step_ena),
    .out_data(out_data), .out_row(out_row), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
`ifdef CONWAY_SCAN_POPCOUNT_EN
    , .out_alive(out_alive)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Frame model: words still to be delivered, wait progress, pending step.
  logic [COLS-1:0] m_q[$];
  int              m_wait = 0;
  bit              m_step = 0;
  int              m_alive = 0;

  // Words the sink actually took, plus bookkeeping.
  logic [COLS-1:0] acc[$];
  logic [COLS-1:0] pend_data = '0;
  bit              pend_valid = 0;
  int              steps = 0;
  bit              integ = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Next Life generation on a non-wrapping 4x4 board.
  function automatic logic [15:0] life(input logic [15:0] b);
    logic [15:0] n_b;
    int n, rr, cc;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < 4 && cc >= 0 && cc < 4)
              n += int'(b[rr*4+cc]);
          end
        n_b[r*4+c] = (n == 3) || (b[r*4+c] && n == 2);
      end
    return n_b;
  endfunction

  task automatic model_step();
    if (pend_valid && out_ready && !rst) acc.push_back(pend_data);
    if (rst) begin
      m_q.delete(); m_wait = 0; m_step = 0; m_alive = 0;
    end else if (m_step) begin
      m_step = 0; m_wait = 0;
    end else if (m_q.size() != 0) begin
      if (out_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_step = 1;
      end
    end else if (m_wait == STEP_CYCLES-1) begin
      for (int r = 0; r < ROWS; r++) m_q.push_back(cells_q[r*COLS +: COLS]);
      m_alive = $countones(cells_q);
      m_wait = 0;
    end else begin
      m_wait++;
    end
  endtask

  task automatic compare();
    bit ev;
    ev = (m_q.size() != 0);
    chk("valid", out_valid, ev);
    chk("step_ena", step_ena, m_step);
    chk("busy", busy, ev || m_step);
    if (ev) begin
      chk("data", out_data, m_q[0]);
      chk("row", out_row, ROWS - m_q.size());
      chk("last", out_last, m_q.size() == 1);
    end else begin
      chk("last_idle", out_last, 0);
    end
`ifdef CONWAY_SCAN_POPCOUNT_EN
    chk("alive", out_alive, m_alive);
`endif
    if (step_ena === 1'b1) steps++;
    pend_valid = (out_valid === 1'b1);
    pend_data  = out_data;
    // The real cells advance on the edge after step_ena is seen.
    if (integ && step_ena === 1'b1) cells_q = life(cells_q);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_valid_rise(output int n);
    bit low;
    n = 0;
    low = (out_valid !== 1'b1);
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (out_valid !== 1'b1) low = 1;
      else if (low) return;
    end
    chk("timeout_valid_rise", 0, 1);
  endtask

  task automatic wait_step();
    for (int i = 0; i < 200; i++) begin
      tick();
      if (step_ena === 1'b1) return;
    end
    chk("timeout_step", 0, 1);
  endtask

  task automatic chk_frame(input string name, input logic [15:0] exp);
    chk({name, "_count"}, acc.size(), ROWS);
    if (acc.size() == ROWS)
      chk(name, {acc[3], acc[2], acc[1], acc[0]}, exp);
  endtask

  initial begin
    int n;
    bit found;

    // 1: reset values, first latency, frame period
    rst = 1'b1; cells_q = 16'h0000; out_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_row", out_row, 0);
    chk("rst_last", out_last, 0);
    chk("rst_step", step_ena, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0; acc.delete(); steps = 0;
    wait_valid_rise(n);
    chk("t1_first_latency", n, 3);
    wait_valid_rise(n);
    chk("t1_frame_period", n, 8);
    chk("t1_steps", steps, 1);
    chk_frame("t1_frame", 16'h0000);

    // 2: patterned board
    cells_q = 16'h0270;
    wait_valid_rise(n);
    acc.delete();
    wait_step();
    chk_frame("t2_frame", 16'h0270);

    // 3: backpressure on row 1 while cells_q changes
    out_ready = 1'b0;
    wait_valid_rise(n);
    acc.delete();
    chk("t3_row0", out_row, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_data", out_data, 4'h7);
      chk("t3_hold_row", out_row, 1);
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_no_step", step_ena, 0);
      cells_q = ~cells_q;
    end
    cells_q = 16'h0270;
    out_ready = 1'b1;
    wait_step();
    chk_frame("t3_frame", 16'h0270);

    // 4: reset in the middle of a frame
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (out_valid === 1'b1 && out_row == 2'd2) found = 1;
    end
    chk("t4_reached_row2", found, 1);
    rst = 1'b1; steps = 0;
    tick();
    chk("t4_valid", out_valid, 0);
    chk("t4_busy", busy, 0);
    rst = 1'b0;
    wait_valid_rise(n);
    chk("t4_restart_latency", n, 3);
    chk("t4_restart_row", out_row, 0);
    chk("t4_no_step", steps, 0);

    // 5: blinker driven by step_ena through a behavioural cell array
    cells_q = 16'h0222; integ = 1;
    wait_step();
    for (int f = 0; f < 4; f++) begin
      steps = 0;
      wait_valid_rise(n);
      acc.delete();
      wait_step();
      chk_frame("t5_blinker", (f % 2 == 0) ? 16'h0070 : 16'h0222);
      chk("t5_one_step", steps, 1);
    end
    integ = 0;

    // 6: population count (full board, then sparse)
    cells_q = 16'hFFFF;
    wait_valid_rise(n);
`ifdef CONWAY_SCAN_POPCOUNT_EN
    chk("t6_alive_full", out_alive, 16);
`endif
    acc.delete();
    wait_step();
    chk_frame("t6_full", 16'hFFFF);
    cells_q = 16'h0270;
    wait_valid_rise(n);
`ifdef CONWAY_SCAN_POPCOUNT_EN
    chk("t6_alive_sparse", out_alive, 4);
`endif
    wait_step();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
